// File: rtl/vector_fetcher.sv
// ---------------------------------------------------------------------------
// vector_fetcher
//
// Read-side sequencer for the image vector RAM. A start request in IDLE
// walks the consecutive 128-byte chunks of one stored image
// (address = image*CHUNKS + chunk). It absorbs the one-cycle BRAM read
// latency and presents each chunk on a valid/ready stream, tagged with its
// chunk index and a last flag.
//
// Build option:
//   VECTOR_FETCH_SKIP_PAD_EN  defined   -> only chunks 0..CHUNKS-2 are
//                                          fetched; the final pad chunk is
//                                          skipped.
//                             undefined -> all CHUNKS chunks are fetched.
//
// Ports:
//   clk        in   single clock, all state on rising edge
//   rst        in   asynchronous active-high reset
//   start      in   fetch request, sampled only in IDLE
//   image      in   image index to fetch
//   busy       out  fetch in progress
//   done       out  one-cycle pulse after the last chunk is accepted
//   err        out  one-cycle pulse on start with image >= NUM_IMAGES
//   ram_addr   out  RAM read address
//   ram_we     out  RAM write enable, tied low
//   ram_dout   in   RAM read data, valid the cycle after the address edge
//   out_data   out  chunk payload, byte k at bits [8k+7:8k]
//   out_chunk  out  chunk index of out_data
//   out_last   out  final chunk of the image
//   out_valid  out  out_data valid
//   out_ready  in   downstream accepts when out_valid & out_ready
// ---------------------------------------------------------------------------
module vector_fetcher #(
    parameter int NUM_IMAGES = 10,
    parameter int CHUNKS     = 8,
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        image,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [DATA_W-1:0] out_data,
    output logic [2:0]        out_chunk,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready
);

`ifdef VECTOR_FETCH_SKIP_PAD_EN
    localparam int NUM_FETCH = CHUNKS - 1;
`else
    localparam int NUM_FETCH = CHUNKS;
`endif

    localparam int                IDX_W    = $clog2(CHUNKS + 1);
    localparam logic [IDX_W-1:0]  FETCH_N  = IDX_W'(NUM_FETCH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_FETCH - 1);
    localparam logic [ADDR_W-1:0] CHUNKS_A = ADDR_W'(CHUNKS);

    typedef enum logic {
        S_IDLE,
        S_FETCH
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ADDR_W-1:0] r_base;
    logic [IDX_W-1:0]  r_issue_idx;

    // Tag of the read whose data arrives on ram_dout this cycle
    logic              r_inflight;
    logic [2:0]        r_infl_chunk;
    logic              r_infl_last;

    // 2-entry output FIFO
    logic [DATA_W-1:0] r_fifo_data  [2];
    logic [2:0]        r_fifo_chunk [2];
    logic              r_fifo_last  [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;

    logic              r_done;
    logic              r_err;

    logic              w_start_ok;
    logic              w_start_bad;
    logic              w_pop;
    logic              w_push;
    logic              w_issue;
    logic              w_last_pop;
    logic [2:0]        w_occ;

    assign w_start_ok  = (r_state == S_IDLE) && start && (int'(image) < NUM_IMAGES);
    assign w_start_bad = (r_state == S_IDLE) && start && (int'(image) >= NUM_IMAGES);

    assign out_valid   = (r_count != 2'd0);
    assign out_data    = r_fifo_data[r_rd_ptr];
    assign out_chunk   = r_fifo_chunk[r_rd_ptr];
    assign out_last    = r_fifo_last[r_rd_ptr];

    assign w_pop       = out_valid && out_ready;
    assign w_push      = r_inflight;
    assign w_last_pop  = w_pop && out_last;

    // Occupancy after this edge excluding a new issue: queued + arriving - leaving.
    // A new read may only be issued if there will be room for its data.
    assign w_occ       = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue     = (r_state == S_FETCH) && (r_issue_idx < FETCH_N) && (w_occ < 3'd2);

    assign ram_addr    = r_base + ADDR_W'(r_issue_idx);
    assign ram_we      = 1'b0;
    assign busy        = (r_state == S_FETCH);
    assign done        = r_done;
    assign err         = r_err;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok) w_state_nxt = S_FETCH;
            S_FETCH: if (w_last_pop) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Address sequencing and read tagging
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base       <= '0;
            r_issue_idx  <= '0;
            r_inflight   <= 1'b0;
            r_infl_chunk <= '0;
            r_infl_last  <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_base      <= ADDR_W'(image) * CHUNKS_A;
                r_issue_idx <= '0;
            end else if (w_issue) begin
                r_issue_idx <= r_issue_idx + 1'b1;
            end
            r_inflight <= w_issue;
            if (w_issue) begin
                r_infl_chunk <= r_issue_idx[2:0];
                r_infl_last  <= (r_issue_idx == LAST_IDX);
            end
        end
    end

    // Output FIFO. When full, a push can only coincide with a pop, and the
    // write then lands in the slot being vacated, preserving order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 2; i++) begin
                r_fifo_data[i]  <= '0;
                r_fifo_chunk[i] <= '0;
                r_fifo_last[i]  <= 1'b0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr]  <= ram_dout;
                r_fifo_chunk[r_wr_ptr] <= r_infl_chunk;
                r_fifo_last[r_wr_ptr]  <= r_infl_last;
                r_wr_ptr               <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= w_last_pop;
            r_err  <= w_start_bad;
        end
    end

endmodule

// File: tb/tb_vector_fetcher.sv
module tb_vector_fetcher;

    localparam int DATA_W = 1024;
    localparam int ADDR_W = 7;
`ifdef VECTOR_FETCH_SKIP_PAD_EN
    localparam int NF = 7;
`else
    localparam int NF = 8;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [3:0]        image;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_dout;
    logic [DATA_W-1:0] out_data;
    logic [2:0]        out_chunk;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [2:0]        chunk;
        logic              last;
    } exp_t;

    exp_t              sb[$];
    logic [DATA_W-1:0] mem [128];
    int                checks = 0;
    int                errors = 0;

    vector_fetcher #(
        .NUM_IMAGES(10),
        .CHUNKS    (8),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .image    (image),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_dout (ram_dout),
        .out_data (out_data),
        .out_chunk(out_chunk),
        .out_last (out_last),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM, one cycle latency
    always @(posedge clk) ram_dout <= mem[ram_addr];

    function automatic logic [DATA_W-1:0] word_of(input int a);
        logic [DATA_W-1:0] w;
        for (int k = 0; k < 128; k++) w[8*k +: 8] = 8'((a * 37 + k * 11 + 5) & 255);
        return w;
    endfunction

    task automatic sb_push_image(input int img);
        exp_t e;
        for (int k = 0; k < NF; k++) begin
            e.data  = word_of(img * 8 + k);
            e.chunk = 3'(k);
            e.last  = (k == NF - 1);
            sb.push_back(e);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_status got busy=%b done=%b err=%b expected 0 0 0", busy, done, err);
        end
        checks++;
        if (ram_addr !== 7'd0 || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_ram got addr=%0d we=%b expected 0 0", ram_addr, ram_we);
        end
        checks++;
        if (out_valid !== 1'b0 || out_chunk !== 3'd0 || out_last !== 1'b0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_out got valid=%b chunk=%0d last=%b data_nonzero=%b expected 0 0 0 0",
                     out_valid, out_chunk, out_last, |out_data);
        end
    endtask

    task automatic test_full_rate();
        exp_t e;
        int   npop = 0;
        @(negedge clk);
        start = 1'b1; image = 4'd3; out_ready = 1'b1;
        sb_push_image(3);
        for (int c = 0; c <= NF + 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c < NF) begin
                checks++;
                if (ram_addr !== 7'(24 + c)) begin
                    errors++;
                    $display("FAIL full_rate_addr cycle %0d got %0d expected %0d", c, ram_addr, 24 + c);
                end
            end
            checks++;
            if (busy !== (c < NF + 2) || done !== (c == NF + 2)) begin
                errors++;
                $display("FAIL full_rate_status cycle %0d got busy=%b done=%b expected busy=%b done=%b",
                         c, busy, done, c < NF + 2, c == NF + 2);
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL full_rate_extra got chunk=%0d expected no output", out_chunk);
                end else begin
                    e = sb.pop_front();
                    if (out_data !== e.data || out_chunk !== e.chunk || out_last !== e.last) begin
                        errors++;
                        $display("FAIL full_rate_chunk got chunk=%0d last=%b data=%h expected chunk=%0d last=%b data=%h",
                                 out_chunk, out_last, out_data[127:0], e.chunk, e.last, e.data[127:0]);
                    end
                end
                npop++;
            end
        end
        checks++;
        if (npop != NF) begin
            errors++;
            $display("FAIL full_rate_count got %0d chunks expected %0d", npop, NF);
        end
    endtask

    task automatic test_toggle();
        exp_t e;
        int   npop = 0;
        @(negedge clk);
        start = 1'b1; image = 4'd9; out_ready = 1'b0;
        sb_push_image(9);
        for (int c = 0; c < 80 && npop < NF; c++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (int'(ram_addr) - 72 - npop > 2) begin
                errors++;
                $display("FAIL toggle_occupancy got %0d outstanding expected at most 2", int'(ram_addr) - 72 - npop);
            end
            out_ready = (c % 2 == 0);
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL toggle_extra got chunk=%0d expected no output", out_chunk);
                end else begin
                    e = sb.pop_front();
                    if (out_data !== e.data || out_chunk !== e.chunk || out_last !== e.last) begin
                        errors++;
                        $display("FAIL toggle_chunk got chunk=%0d last=%b data=%h expected chunk=%0d last=%b data=%h",
                                 out_chunk, out_last, out_data[127:0], e.chunk, e.last, e.data[127:0]);
                    end
                end
                npop++;
            end
        end
        checks++;
        if (npop != NF) begin
            errors++;
            $display("FAIL toggle_count got %0d chunks expected %0d", npop, NF);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL toggle_done got done=%b busy=%b expected 1 0", done, busy);
        end
    endtask

    task automatic test_stall();
        exp_t e;
        int   npop = 0;
        @(negedge clk);
        start = 1'b1; image = 4'd5; out_ready = 1'b0;
        sb_push_image(5);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || out_chunk !== 3'd0 || out_data !== sb[0].data) begin
                    errors++;
                    $display("FAIL stall_hold cycle %0d got valid=%b chunk=%0d data=%h expected 1 0 %h",
                             c, out_valid, out_chunk, out_data[127:0], sb[0].data[127:0]);
                end
            end
        end
        checks++;
        if (ram_addr !== 7'd42) begin
            errors++;
            $display("FAIL stall_reads got addr=%0d expected 42", ram_addr);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 40 && npop < NF; c++) begin
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL stall_extra got chunk=%0d expected no output", out_chunk);
                end else begin
                    e = sb.pop_front();
                    if (out_data !== e.data || out_chunk !== e.chunk || out_last !== e.last) begin
                        errors++;
                        $display("FAIL stall_chunk got chunk=%0d last=%b data=%h expected chunk=%0d last=%b data=%h",
                                 out_chunk, out_last, out_data[127:0], e.chunk, e.last, e.data[127:0]);
                    end
                end
                npop++;
            end
            @(negedge clk);
        end
        checks++;
        if (npop != NF || done !== 1'b1) begin
            errors++;
            $display("FAIL stall_release got %0d chunks done=%b expected %0d chunks done=1", npop, done, NF);
        end
    endtask

    task automatic test_err(input int exp_addr);
        @(negedge clk);
        start = 1'b1; image = 4'd10;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || ram_addr !== 7'(exp_addr)) begin
            errors++;
            $display("FAIL err_img10 got err=%b busy=%b addr=%0d expected 1 0 %0d", err, busy, ram_addr, exp_addr);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse got err=%b busy=%b expected 0 0", err, busy);
        end
        start = 1'b1; image = 4'd15;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || ram_addr !== 7'(exp_addr)) begin
            errors++;
            $display("FAIL err_img15 got err=%b busy=%b addr=%0d expected 1 0 %0d", err, busy, ram_addr, exp_addr);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   npop = 0;
        bit   seen = 0;
        @(negedge clk);
        start = 1'b1; image = 4'd4; out_ready = 1'b1;
        sb_push_image(4);
        for (int c = 0; c < 30 && !seen; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) begin
                seen = 1;
            end else if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_first_extra got chunk=%0d expected no output", out_chunk);
                end else begin
                    e = sb.pop_front();
                    if (out_data !== e.data || out_chunk !== e.chunk || out_last !== e.last) begin
                        errors++;
                        $display("FAIL b2b_first_chunk got chunk=%0d last=%b data=%h expected chunk=%0d last=%b data=%h",
                                 out_chunk, out_last, out_data[127:0], e.chunk, e.last, e.data[127:0]);
                    end
                end
                npop++;
            end
        end
        checks++;
        if (!seen || npop != NF) begin
            errors++;
            $display("FAIL b2b_first_done got done_seen=%0d chunks=%0d expected 1 %0d", seen, npop, NF);
        end
        start = 1'b1; image = 4'd7;
        sb_push_image(7);
        npop = 0;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || ram_addr !== 7'd56 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept got busy=%b addr=%0d done=%b expected 1 56 0", busy, ram_addr, done);
        end
        for (int c = 0; c < 30 && npop < NF; c++) begin
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_second_extra got chunk=%0d expected no output", out_chunk);
                end else begin
                    e = sb.pop_front();
                    if (out_data !== e.data || out_chunk !== e.chunk || out_last !== e.last) begin
                        errors++;
                        $display("FAIL b2b_second_chunk got chunk=%0d last=%b data=%h expected chunk=%0d last=%b data=%h",
                                 out_chunk, out_last, out_data[127:0], e.chunk, e.last, e.data[127:0]);
                    end
                end
                npop++;
            end
            @(negedge clk);
        end
        checks++;
        if (npop != NF || done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_done got %0d chunks done=%b expected %0d chunks done=1", npop, done, NF);
        end
    endtask

    task automatic test_rst_mid();
        exp_t e;
        int   npop = 0;
        @(negedge clk);
        start = 1'b1; image = 4'd2; out_ready = 1'b1;
        sb_push_image(2);
        for (int c = 0; c < 30 && npop < 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rst_pre_extra got chunk=%0d expected no output", out_chunk);
                end else begin
                    e = sb.pop_front();
                    if (out_data !== e.data || out_chunk !== e.chunk || out_last !== e.last) begin
                        errors++;
                        $display("FAIL rst_pre_chunk got chunk=%0d last=%b data=%h expected chunk=%0d last=%b data=%h",
                                 out_chunk, out_last, out_data[127:0], e.chunk, e.last, e.data[127:0]);
                    end
                end
                npop++;
            end
        end
        // chunk 3 is accepted at the next rising edge; assert reset after it
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || ram_addr !== 7'd0) begin
            errors++;
            $display("FAIL rst_async_status got busy=%b done=%b err=%b addr=%0d expected 0 0 0 0",
                     busy, done, err, ram_addr);
        end
        checks++;
        if (out_valid !== 1'b0 || out_chunk !== 3'd0 || out_last !== 1'b0 || out_data !== '0) begin
            errors++;
            $display("FAIL rst_async_out got valid=%b chunk=%0d last=%b data_nonzero=%b expected 0 0 0 0",
                     out_valid, out_chunk, out_last, |out_data);
        end
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start = 1'b1; image = 4'd0;
        sb_push_image(0);
        npop = 0;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || ram_addr !== 7'd0) begin
            errors++;
            $display("FAIL rst_restart got busy=%b addr=%0d expected 1 0", busy, ram_addr);
        end
        for (int c = 0; c < 30 && npop < NF; c++) begin
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rst_post_extra got chunk=%0d expected no output", out_chunk);
                end else begin
                    e = sb.pop_front();
                    if (out_data !== e.data || out_chunk !== e.chunk || out_last !== e.last) begin
                        errors++;
                        $display("FAIL rst_post_chunk got chunk=%0d last=%b data=%h expected chunk=%0d last=%b data=%h",
                                 out_chunk, out_last, out_data[127:0], e.chunk, e.last, e.data[127:0]);
                    end
                end
                npop++;
            end
            @(negedge clk);
        end
        checks++;
        if (npop != NF || done !== 1'b1 || sb.size() != 0) begin
            errors++;
            $display("FAIL rst_post_done got %0d chunks done=%b left=%0d expected %0d chunks done=1 left=0",
                     npop, done, sb.size(), NF);
        end
    endtask

    initial begin
        for (int a = 0; a < 128; a++) mem[a] = word_of(a);
        rst       = 1'b1;
        start     = 1'b0;
        image     = 4'd0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_full_rate();
        test_toggle();
        test_stall();
        test_err(5 * 8 + NF);
        test_back_to_back();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vector_fetcher.md
# vector_fetcher

Read-side sequencer for the image vector RAM: on a start request it walks the 8 consecutive 128-byte chunks of one stored image (address = image*8 + chunk), absorbs the one-cycle BRAM read latency, and presents each chunk on a valid/ready stream with chunk index and last flag. It sits directly upstream of the downstream datapath and drives the RAM's address and write-enable ports.

## Interface
- NUM_IMAGES, 10, images stored in the RAM; valid image indices 0..NUM_IMAGES-1
- CHUNKS, 8, chunks per image (128 bytes each)
- ADDR_W, 7, RAM address width
- DATA_W, 1024, chunk width in bits
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request fetch of image `image`; sampled only in IDLE
- image  in  4  image index
- busy  out  1  high from the edge after accepted start until completion
- done  out  1  one-cycle pulse after the last chunk is accepted
- err  out  1  one-cycle pulse: start with image >= NUM_IMAGES
- ram_addr  out  ADDR_W  RAM read address
- ram_we  out  1  RAM write enable, constant 0
- ram_dout  in  DATA_W  RAM read data, valid the cycle after the address edge
- out_data  out  DATA_W  chunk; byte k at bits [8k+7:8k]
- out_chunk  out  3  chunk index 0..7 of out_data
- out_last  out  1  marks final chunk of the image
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts when out_valid & out_ready

## Operation
- States: IDLE, FETCH. IDLE: start & image<NUM_IMAGES -> latch base=image*CHUNKS, issue_idx=0, go FETCH. start & image>=NUM_IMAGES -> err pulse, stay IDLE. start while in FETCH ignored.
- ram_addr = base + issue_idx (combinational from registers). Read issued at an edge when FETCH & issue_idx<CHUNKS & (count + inflight - pop) < 2; issue_idx increments.
- inflight flag set on issue; at the next edge ram_dout is pushed into a 2-entry FIFO tagged with its chunk index and last flag.
- out_* show FIFO head; out_valid = count>0; pop = out_valid & out_ready. out_data/out_chunk/out_last stable while out_valid & !out_ready.
- FETCH -> IDLE at the edge that pops the last chunk; done pulses and busy drops in the following cycle.
- Address arithmetic in ADDR_W bits; max address NUM_IMAGES*CHUNKS-1 = 79, never wraps.

## Timing
- Reset values: busy 0, done 0, err 0, ram_addr 0, ram_we 0, out_valid 0, out_data 0, out_chunk 0, out_last 0; FIFO empty, inflight 0.
- start sampled edge E0; chunk0 address sampled by RAM at E1; out_valid high after E2.
- out_ready held high: one chunk per cycle, pops at E3..E10, done high between E10 and E11.
- Backpressure: issue stalls when FIFO+inflight would exceed 2; no chunk dropped or duplicated.
- Pop with FIFO full and inflight data arriving same edge: both happen, count stays 2.
- rst mid-fetch: immediate return to IDLE, FIFO emptied, inflight cleared; stale ram_dout after reset release is discarded.
- start in the cycle done is high: accepted (state already IDLE).

## Configuration
- VECTOR_FETCH_SKIP_PAD_EN defined: only chunks 0..6 fetched (785-byte image fits in 896 bytes); out_last on chunk 6; done after 7 pops.
- Undefined: all 8 chunks fetched; out_last on chunk 7.

## Test plan
- start, image=3, out_ready=1 -> ram_addr 24..31 on consecutive cycles, out_chunk 0..7, out_last only on chunk 7, done pulse 10 edges after start edge.
- image=9, out_ready toggling 1010... -> 8 chunks in order, data equals RAM words 72..79, FIFO never exceeds 2.
- out_ready=0 for 20 cycles after start -> exactly 2 reads issued, out_data held stable; release -> remaining 6 chunks delivered.
- start with image=10 -> err pulse 1 cycle, busy stays 0, no address change.
- rst asserted after chunk 3 accepted -> all outputs at reset values asynchronously; new start image=0 -> fresh 8-chunk sequence from address 0.
- VECTOR_FETCH_SKIP_PAD_EN build, image=1 -> addresses 8..14 only, out_last on chunk 6, done after 7th pop.
